// File: rtl/ahb_sram_slave.sv
// AHB-lite slave in front of a word SRAM. Data phase takes 1+WAIT_STATES cycles (OKAY) or 2 cycles (ERROR).
// It stalls the bus by holding HREADYOUT low and only takes a new address phase when HREADYOUT is high.
module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic          pend_vld, pend_wr;
  logic [IW-1:0] pend_idx;
  logic [3:0]    pend_mask;
  logic [31:0]   hrdata_q;

  logic [31:0] mem [DEPTH];

  logic          accept, addr_err, complete, wr_commit;
  logic          rd_load_acc, rd_load_wait, rd_load;
  logic [IW-1:0] addr_idx, rd_idx;
  logic [3:0]    addr_mask;
  logic [31:0]   merged, rd_word;
  logic          unused_ok;

  assign unused_ok = ^{HBURST, HPROT};

  assign HREADYOUT = (state == S_IDLE) || (state == S_ERR2);
  assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
  assign HRDATA    = hrdata_q;

  assign accept   = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign addr_err = (HSIZE > 3'd2)
                 || ((HSIZE == 3'd1) && HADDR[0])
                 || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                 || ({1'b0, HADDR} >= LIMIT);
  assign addr_idx = HADDR[IW+1:2];

  always_comb begin
    addr_mask = 4'b1111;
    case (HSIZE)
      3'd0:    addr_mask = 4'b0001 << HADDR[1:0];
      3'd1:    addr_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: addr_mask = 4'b1111;
    endcase
  end

  // The beat completes in the first IDLE cycle after its address phase (or after its wait states).
  assign complete  = (state == S_IDLE) && pend_vld;
  assign wr_commit = complete && pend_wr;

  always_comb begin
    merged = mem[pend_idx];
    for (int l = 0; l < 4; l++) begin
      if (pend_mask[l]) merged[8*l +: 8] = HWDATA[8*l +: 8];
    end
  end

  // Read data is registered one edge ahead of the completing cycle; forward a write committing at that edge.
  assign rd_load_acc  = accept && !addr_err && !HWRITE && (WAIT_STATES == 0);
  assign rd_load_wait = (state == S_WAIT) && (cnt == 4'd1) && !pend_wr;
  assign rd_load      = rd_load_acc || rd_load_wait;
  assign rd_idx       = rd_load_wait ? pend_idx : addr_idx;
  assign rd_word      = (wr_commit && (pend_idx == rd_idx)) ? merged : mem[rd_idx];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_ERR2: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      pend_vld  <= 1'b0;
      pend_wr   <= 1'b0;
      pend_idx  <= '0;
      pend_mask <= 4'd0;
      hrdata_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (HREADYOUT) begin
        pend_vld  <= accept && !addr_err;
        pend_wr   <= HWRITE;
        pend_idx  <= addr_idx;
        pend_mask <= addr_mask;
      end
      if (rd_load) hrdata_q <= rd_word;
    end
  end

  always_ff @(posedge HCLK) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_commit && pend_mask[l]) mem[pend_idx][8*l +: 8] <= HWDATA[8*l +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Drives two slaves (0 and 3 wait states) through directed and random AHB-lite traffic against a byte-level memory model.
module tb_ahb_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hresetn, sel, hsel_v, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hsel0, hsel1, hready;
  logic        ro0, ro1, rs0, rs1;
  logic [31:0] rd0, rd1;
  logic        act_rdy, act_resp;
  logic [31:0] act_rdata;

  assign hsel0     = hsel_v && !sel;
  assign hsel1     = hsel_v && sel;
  assign hready    = sel ? ro1 : ro0;
  assign act_rdy   = sel ? ro1 : ro0;
  assign act_resp  = sel ? rs1 : rs0;
  assign act_rdata = sel ? rd1 : rd0;

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(rs0));

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) dut1 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ro1), .HRDATA(rd1), .HRESP(rs1));

  typedef struct packed {
    logic        vld;
    logic        err;
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } beat_t;

  beat_t       prev;
  int          checks = 0;
  int          errors = 0;
  int          lowcnt = 0;
  int          respcnt = 0;
  logic        chk_en = 1'b0;
  logic        exp_rdy, exp_resp;
  logic [31:0] exp_rdata;
  logic [31:0] last_rd [2];
  logic [7:0]  mdl [2][4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("hreadyout", 32'(act_rdy), 32'(exp_rdy));
      check("hresp", 32'(act_resp), 32'(exp_resp));
      check("hrdata", act_rdata, exp_rdata);
      if (!act_rdy) lowcnt++;
      if (act_resp) respcnt++;
    end
  end

  function automatic bit model_err(input logic [2:0] sz, input logic [31:0] a);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int b;
    b = int'(a[11:0]) & 32'hFFC;
    return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
  endfunction

  task automatic model_write(input int d, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) begin
      int p;
      p = int'(a[11:0]) + i;
      mdl[d][p] = wd[8*(p%4) +: 8];
    end
  endtask

  // Presents one address phase while walking the previous beat's data phase to its completion.
  task automatic beat(input logic s, input logic [1:0] tr, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
    int    d, n;
    beat_t nb;
    d = sel ? 1 : 0;
    hsel_v = s; htrans = tr; hwrite = w; hsize = sz; haddr = a; hwdata = prev.wd;
    if (!prev.vld)     n = 1;
    else if (prev.err) n = 2;
    else               n = (sel ? 3 : 0) + 1;
    for (int k = 0; k < n; k++) begin
      exp_rdy  = (k == n - 1);
      exp_resp = prev.vld && prev.err;
      if (k == n - 1 && prev.vld && !prev.err && !prev.w) last_rd[d] = model_word(d, prev.a);
      exp_rdata = last_rd[d];
      @(posedge clk); #1;
    end
    if (prev.vld && !prev.err && prev.w) model_write(d, prev.sz, prev.a, prev.wd);
    nb.vld = s && tr[1];
    nb.err = nb.vld && model_err(sz, a);
    nb.w = w; nb.sz = sz; nb.a = a; nb.wd = wd;
    prev = nb;
  endtask

  task automatic idle();
    beat(1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    hresetn = 1'b0; sel = 1'b0; hsel_v = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; haddr = 32'd0; hwdata = 32'd0; hburst = 3'd1; hprot = 4'd3;
    prev = '0; last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy0", 32'(ro0), 32'd1);
    check("rst_resp0", 32'(rs0), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_rdy1", 32'(ro1), 32'd1);
    check("rst_resp1", 32'(rs1), 32'd0);
    check("rst_rdata1", rd1, 32'd0);
    @(negedge clk) hresetn = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int i = 0; i < 64; i++) beat(1'b1, 2'b10, 1'b1, 3'd2, 32'(i * 4), $urandom);
      idle();
    end

    // Zero-wait slave: forwarding, lane merging, errors, ignored transfers.
    sel = 1'b0;
    lowcnt = 0;
    beat(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'd0);
    idle();
    check("t1_rdata", rd0, 32'hDEADBEEF);
    check("t1_lowcycles", 32'(lowcnt), 32'd0);

    beat(1'b1, 2'b10, 1'b1, 3'd2, 32'h20, 32'h0);
    beat(1'b1, 2'b10, 1'b1, 3'd0, 32'h21, 32'h0000AA00);
    beat(1'b1, 2'b11, 1'b1, 3'd1, 32'h22, 32'h12340000);
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'd0);
    idle();
    check("t2_rdata", rd0, 32'h1234AA00);
    check("t2_model", last_rd[0], 32'h1234AA00);

    lowcnt = 0; respcnt = 0;
    beat(1'b1, 2'b10, 1'b1, 3'd2, 32'h22, 32'hFFFFFFFF);
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'd4096, 32'd0);
    idle();
    check("t4_rdata_held", rd0, 32'h1234AA00);
    check("t4_lowcycles", 32'(lowcnt), 32'd2);
    check("t4_respcycles", 32'(respcnt), 32'd4);
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'd0);
    idle();
    check("t4_sram_kept", rd0, 32'h1234AA00);

    lowcnt = 0; respcnt = 0;
    beat(1'b1, 2'b00, 1'b1, 3'd2, 32'h20, 32'h11111111);
    beat(1'b1, 2'b01, 1'b1, 3'd2, 32'h20, 32'h22222222);
    beat(1'b0, 2'b10, 1'b1, 3'd2, 32'h20, 32'h33333333);
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'd0);
    idle();
    check("t5_rdata", rd0, 32'h1234AA00);
    check("t5_lowcycles", 32'(lowcnt), 32'd0);
    check("t5_respcycles", 32'(respcnt), 32'd0);

    // Three-wait-state slave.
    sel = 1'b1;
    lowcnt = 0;
    beat(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D);
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'd0);
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'd0);
    idle();
    check("t3_rdata", rd1, 32'hCAFEF00D);
    check("t3_lowcycles", 32'(lowcnt), 32'd9);

    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int i = 0; i < 300; i++) begin
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] a;
        int          r;
        r  = $urandom_range(0, 9);
        tr = (r < 7) ? ((r % 2) ? 2'b10 : 2'b11) : ((r == 7) ? 2'b00 : 2'b01);
        r  = $urandom_range(0, 19);
        sz = (r < 19) ? 3'(r % 3) : 3'($urandom_range(3, 7));
        r  = $urandom_range(0, 19);
        if (r < 18)       a = 32'($urandom_range(0, 255));
        else if (r == 18) a = 32'd4096 + 32'($urandom_range(0, 4000));
        else              a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
        if (sz < 3'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        beat($urandom_range(0, 9) != 0, tr, 1'($urandom), sz, a, $urandom);
      end
      idle();
    end

    // Reset in the middle of a stalled write.
    sel = 1'b1;
    beat(1'b1, 2'b10, 1'b1, 3'd2, 32'h40, 32'h5A5A0F0F);
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'd0);
    idle();
    check("t6_pre_rdata", rd1, 32'h5A5A0F0F);
    chk_en = 1'b0;
    hsel_v = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(posedge clk); #1;
    hsel_v = 1'b0; htrans = 2'b00; hwdata = 32'h0BADF00D;
    @(posedge clk); #1;
    check("t6_in_wait", 32'(ro1), 32'd0);
    @(negedge clk);
    hresetn = 1'b0;
    #1;
    check("t6_rst_rdy", 32'(ro1), 32'd1);
    check("t6_rst_resp", 32'(rs1), 32'd0);
    check("t6_rst_rdata1", rd1, 32'd0);
    check("t6_rst_rdata0", rd0, 32'd0);
    @(posedge clk);
    @(negedge clk) hresetn = 1'b1;
    prev = '0; last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    beat(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'd0);
    idle();
    check("t6_word_kept", rd1, 32'h5A5A0F0F);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
